// File: rtl/gfx_write_arbiter_if.sv
// gfx_write_arbiter_if: engine-side and DDR-side write-path signals of the graphics write arbiter.
// Ports (all carried in the interface):
//   req_af_wr_en/req_af_addr_din      per-engine address FIFO writes (31 bits per engine)
//   req_wdf_wr_en/req_wdf_din/req_wdf_mask_din  per-engine data FIFO writes (128 data + 16 mask bits per engine)
//   req_af_full/req_wdf_full          per-engine FIFO full flags as seen by each engine
//   af_full/wdf_full                  DDR FIFO full flags
//   af_wr_en/af_addr_din              DDR address FIFO write
//   wdf_wr_en/wdf_din/wdf_mask_din    DDR data FIFO write
//   grant_valid/grant_idx             current owner of the write path
// Modports: slave = arbiter, master = engines plus DDR FIFOs (the environment).
interface gfx_write_arbiter_if #(parameter int NUM_REQ = 3);
    logic [NUM_REQ-1:0]     req_af_wr_en;
    logic [NUM_REQ*31-1:0]  req_af_addr_din;
    logic [NUM_REQ-1:0]     req_wdf_wr_en;
    logic [NUM_REQ*128-1:0] req_wdf_din;
    logic [NUM_REQ*16-1:0]  req_wdf_mask_din;
    logic [NUM_REQ-1:0]     req_af_full;
    logic [NUM_REQ-1:0]     req_wdf_full;
    logic                   af_full;
    logic                   wdf_full;
    logic                   af_wr_en;
    logic [30:0]            af_addr_din;
    logic                   wdf_wr_en;
    logic [127:0]           wdf_din;
    logic [15:0]            wdf_mask_din;
    logic                   grant_valid;
    logic [2:0]             grant_idx;

    modport slave (
        input  req_af_wr_en, req_af_addr_din, req_wdf_wr_en, req_wdf_din, req_wdf_mask_din,
        input  af_full, wdf_full,
        output req_af_full, req_wdf_full, af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din,
        output grant_valid, grant_idx
    );

    modport master (
        output req_af_wr_en, req_af_addr_din, req_wdf_wr_en, req_wdf_din, req_wdf_mask_din,
        output af_full, wdf_full,
        input  req_af_full, req_wdf_full, af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din,
        input  grant_valid, grant_idx
    );
endinterface

// File: rtl/gfx_write_arbiter.sv
// gfx_write_arbiter: shares the DDR address/data write FIFOs among NUM_REQ engines, one 1-address + 2-beat transaction per grant.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  gfx_write_arbiter_if.slave carrying all engine-side and DDR-side write signals
// Configuration: define GFX_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins);
//   default is round-robin starting after the last granted engine.
module gfx_write_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                clk,
    input  logic                rst,
    gfx_write_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_idx_q, grant_idx_d;
    logic [2:0]         last_idx_q, last_idx_d;
    logic               af_done_q, af_done_d;
    logic [1:0]         wdf_cnt_q, wdf_cnt_d;
    logic [2:0]         win_idx;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_af_full, req_wdf_full;
    logic               af_wr_en, wdf_wr_en;

    assign req = bus.req_af_wr_en | bus.req_wdf_wr_en;

    // Later loop iterations override earlier ones, so the loops run from lowest to highest priority.
    always_comb begin
        win_idx = '0;
`ifdef GFX_ARB_FIXED_PRIORITY_EN
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[k]) win_idx = 3'(k);
`else
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[(int'(last_idx_q) + k) % NUM_REQ]) win_idx = 3'((int'(last_idx_q) + k) % NUM_REQ);
`endif
    end

    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        last_idx_d   = last_idx_q;
        af_done_d    = af_done_q;
        wdf_cnt_d    = wdf_cnt_q;
        req_af_full  = '1;
        req_wdf_full = '1;
        af_wr_en     = 1'b0;
        wdf_wr_en    = 1'b0;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d     = GRANT;
                grant_idx_d = win_idx;
                af_done_d   = 1'b0;
                wdf_cnt_d   = 2'd0;
            end
        end else begin
            // Once the address or both beats are in, the owner sees full so nothing extra leaks through.
            req_af_full[grant_idx_q]  = bus.af_full | af_done_q;
            req_wdf_full[grant_idx_q] = bus.wdf_full | (wdf_cnt_q == 2'd2);
            af_wr_en  = bus.req_af_wr_en[grant_idx_q] & ~bus.af_full & ~af_done_q;
            wdf_wr_en = bus.req_wdf_wr_en[grant_idx_q] & ~bus.wdf_full & (wdf_cnt_q != 2'd2);
            af_done_d = af_done_q | af_wr_en;
            wdf_cnt_d = wdf_cnt_q + {1'b0, wdf_wr_en};
            // Completion counts acceptances of this same cycle.
            if (af_done_d && wdf_cnt_d == 2'd2) begin
                state_d    = IDLE;
                last_idx_d = grant_idx_q;
                af_done_d  = 1'b0;
                wdf_cnt_d  = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= 3'(NUM_REQ - 1);
            af_done_q   <= 1'b0;
            wdf_cnt_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            af_done_q   <= af_done_d;
            wdf_cnt_q   <= wdf_cnt_d;
        end
    end

    assign bus.req_af_full  = req_af_full;
    assign bus.req_wdf_full = req_wdf_full;
    assign bus.af_wr_en     = af_wr_en;
    assign bus.wdf_wr_en    = wdf_wr_en;
    assign bus.af_addr_din  = bus.req_af_addr_din[31*grant_idx_q +: 31];
    assign bus.wdf_din      = bus.req_wdf_din[128*grant_idx_q +: 128];
    assign bus.wdf_mask_din = bus.req_wdf_mask_din[16*grant_idx_q +: 16];
    assign bus.grant_valid  = (state_q == GRANT);
    assign bus.grant_idx    = grant_idx_q;
endmodule

// File: doc/gfx_write_arbiter.md
# gfx_write_arbiter

Shares the single DDR write path (address FIFO `af_*` and write-data FIFO `wdf_*`) between several graphics engines such as the circle, line and fill engines. Each engine drives its own `af_*`/`wdf_*` signals as if it owned the FIFOs. The arbiter grants exactly one engine at a time and holds that grant for one complete DDR write transaction: 1 address entry plus 2 data beats. All non-granted engines see their FIFOs as full, so they stall in place.

## Interface
- `NUM_REQ`, 3, number of requesting engines (2..8); index 0 is the circle engine by convention
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `req_af_wr_en`  in  NUM_REQ  per-engine address write enable; held high while stalled
- `req_af_addr_din`  in  NUM_REQ*31  per-engine address; engine i occupies bits [31*i+30:31*i]
- `req_wdf_wr_en`  in  NUM_REQ  per-engine data write enable; held high while stalled
- `req_wdf_din`  in  NUM_REQ*128  per-engine write data; engine i occupies [128*i+127:128*i]
- `req_wdf_mask_din`  in  NUM_REQ*16  per-engine byte mask (1 = byte not written); engine i occupies [16*i+15:16*i]
- `req_af_full`  out  NUM_REQ  per-engine address-FIFO full as seen by the engine
- `req_wdf_full`  out  NUM_REQ  per-engine data-FIFO full as seen by the engine
- `af_full`  in  1  DDR address FIFO full
- `wdf_full`  in  1  DDR write-data FIFO full
- `af_wr_en`  out  1  address FIFO write enable
- `af_addr_din`  out  31  address FIFO data
- `wdf_wr_en`  out  1  data FIFO write enable
- `wdf_din`  out  128  data FIFO data
- `wdf_mask_din`  out  16  data FIFO mask
- `grant_valid`  out  1  an engine currently holds the grant
- `grant_idx`  out  3  index of the granted engine; meaningful only when `grant_valid` = 1

## Operation
- **Request definition:** engine i is requesting when `req_af_wr_en[i] | req_wdf_wr_en[i]`.
- **States:**
  - IDLE: no grant.
  - GRANT: `grant_idx` is locked.
- **IDLE:**
  - All `req_af_full` and `req_wdf_full` bits are 1.
  - `af_wr_en` = `wdf_wr_en` = 0.
  - If any engine is requesting, select a winner, register it into `grant_idx`, clear the counters, and go to GRANT.
- **Winner selection (default):** round-robin. The search starts at `last_idx+1` modulo NUM_REQ. `last_idx` is the most recently granted engine and resets to NUM_REQ-1, so the first arbitration favours engine 0.
- **GRANT, signal routing:**
  - Granted engine: `req_af_full[g]` = `af_full` and `req_wdf_full[g]` = `wdf_full`. Every other engine's full bits stay 1.
  - `af_wr_en` = `req_af_wr_en[g] & ~af_full & ~af_done`.
  - `wdf_wr_en` = `req_wdf_wr_en[g] & ~wdf_full & (wdf_cnt != 2)`.
  - Address, data and mask outputs are muxed from engine g.
- **GRANT, transaction counting:**
  - An address is accepted when `af_wr_en` = 1; this sets `af_done`.
  - A data beat is accepted when `wdf_wr_en` = 1; this increments the 2-bit `wdf_cnt`.
  - Address and data beats may arrive in either order or in the same cycle.
  - After `af_done` is set, `req_af_full[g]` is forced to 1. After `wdf_cnt` = 2, `req_wdf_full[g]` is forced to 1. This prevents a third beat or a second address from leaking through.
- **Release:** the transaction is complete in the cycle where, counting acceptances in that same cycle, `af_done` = 1 and `wdf_cnt` = 2. On the next edge: go to IDLE, set `last_idx` = g, and clear the counters.
- **Requester drops mid-transaction:** the grant is held regardless, with no timeout. Engines must complete every transaction they start.
- **Data path:** no buffering; outputs are combinational from the granted engine's inputs.

## Timing
- **Reset values:** state = IDLE, `grant_valid` = 0, `grant_idx` = 0, `last_idx` = NUM_REQ-1, `af_done` = 0, `wdf_cnt` = 0, all `req_*_full` = 1, `af_wr_en` = 0, `wdf_wr_en` = 0. Muxed data outputs are don't-care but are driven from engine 0.
- **Grant latency:** 1 cycle from the first requesting cycle in IDLE to the first possible accepted write.
- **Minimum transaction length:** 2 cycles in GRANT (address + beat 1, then beat 2), followed by 1 IDLE cycle. Peak throughput is therefore 1 transaction per 3 cycles.
- **Stalls:** `af_full` or `wdf_full` stall only the granted engine and do not affect grant ownership.
- **Reset mid-transaction:** the arbiter returns to IDLE immediately. Partial FIFO contents are not the arbiter's concern.
- **Simultaneous requests in IDLE:** exactly one winner; losers keep seeing full = 1.

## Configuration
- Macro: `GFX_ARB_FIXED_PRIORITY_EN`.
- **Defined:** winner selection is fixed priority, lowest index wins; `last_idx` is still maintained but ignored.
- **Undefined:** round-robin as described under Operation.

## Test plan
- **Single engine:** engine 0 writes address 0x0040_0000 with beats A and B, full = 0 → `grant_idx` = 0 one cycle after the request; `af_wr_en` fires once; `wdf_wr_en` fires twice with A then B; IDLE follows.
- **Contention, round-robin:** engines 0, 1 and 2 all request continuously from reset → grant order is 0, 1, 2, 0; each grant covers exactly 1 address and 2 beats; outputs never interleave engines.
- **Contention, fixed priority:** same stimulus with `GFX_ARB_FIXED_PRIORITY_EN` defined → engine 0 wins every arbitration while it keeps requesting.
- **Backpressure:** `wdf_full` = 1 for 5 cycles after beat 1 → `req_wdf_full[g]` = 1 for those cycles; no `wdf_wr_en`; grant is held; beat 2 is accepted when `wdf_full` falls.
- **Third-beat guard:** the granted engine holds `req_wdf_wr_en` high for 3 beats → only 2 `wdf_wr_en` pulses occur and the third beat waits for the next grant.
- **Reset mid-transaction:** assert `rst` after the address is accepted but before the beats → next cycle IDLE, `grant_valid` = 0, all full bits = 1, counters = 0.
